// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates instruction fetch against the load/store
// buffer and turns each 1/2/4-byte access into byte-serial RAM cycles,
// assembling little-endian read data and pulsing a one-cycle completion.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy_i,
  input  logic        lsb_enable_i,
  input  logic        lsb_is_write_i,
  input  logic [31:0] lsb_addr_i,
  input  logic [2:0]  lsb_len_i,
  input  logic [31:0] lsb_wdata_i,
  output logic        lsb_data_valid_o,
  output logic [31:0] lsb_data_o,
  input  logic        if_enable_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_clear_i,
  output logic        if_data_valid_o,
  output logic [31:0] if_data_o,
  input  logic [7:0]  mem_din_i,
  output logic [7:0]  mem_dout_o,
  output logic [31:0] mem_a_o,
  output logic        mem_wr_o,
  input  logic        io_buffer_full_i
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, GAP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] lsbData_q, lsbData_d;
  logic [31:0] ifData_q, ifData_d;
  logic [2:0]  len_q, len_d;
  logic [2:0]  k_q, k_d;
  logic        srcIf_q, srcIf_d;
  logic        pend_q, pend_d;
  logic        lsbValid_q, lsbValid_d;
  logic        ifValid_q, ifValid_d;

  logic [31:0] byteAddr;
  logic [31:0] prevAddr;
  logic [7:0]  wrByte;
  logic [31:0] rxAsm;
  logic [1:0]  rxIdx;
  logic        ioStall;

  // Byte count of a request; anything that is not 1 or 2 becomes a word.
  function automatic logic [2:0] decodeLen(input logic [2:0] l);
    case (l)
      3'b001:  return 3'd1;
      3'b010:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Per-byte datapath: current address, the outstanding read address to
  // re-request while frozen, the write byte and the read-assembly merge.
  always_comb begin
    byteAddr = addr_q + {29'd0, k_q};
    prevAddr = byteAddr - {31'd0, pend_q};
    ioStall  = (byteAddr[17:16] == 2'b11) && io_buffer_full_i;
    rxIdx    = k_q[1:0] - 2'd1;
    rxAsm    = asm_q;
    case (rxIdx)
      2'd0: rxAsm[7:0]   = mem_din_i;
      2'd1: rxAsm[15:8]  = mem_din_i;
      2'd2: rxAsm[23:16] = mem_din_i;
      default: rxAsm[31:24] = mem_din_i;
    endcase
    case (k_q[1:0])
      2'd0: wrByte = wdata_q[7:0];
      2'd1: wrByte = wdata_q[15:8];
      2'd2: wrByte = wdata_q[23:16];
      default: wrByte = wdata_q[31:24];
    endcase
  end

  // Next-state and RAM bus outputs; rdy low freezes everything except the
  // read address, which replays the outstanding byte so it is valid on resume.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    asm_d      = asm_q;
    lsbData_d  = lsbData_q;
    ifData_d   = ifData_q;
    len_d      = len_q;
    k_d        = k_q;
    srcIf_d    = srcIf_q;
    pend_d     = pend_q;
    lsbValid_d = 1'b0;
    ifValid_d  = 1'b0;
    mem_a_o    = 32'd0;
    mem_dout_o = 8'd0;
    mem_wr_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rdy_i) begin
          if (lsb_enable_i) begin
            addr_d  = lsb_addr_i;
            len_d   = decodeLen(lsb_len_i);
            wdata_d = lsb_wdata_i;
            srcIf_d = 1'b0;
            k_d     = 3'd0;
            pend_d  = 1'b0;
            asm_d   = 32'd0;
            state_d = lsb_is_write_i ? WRITE : READ;
          end else if (if_enable_i && !if_clear_i) begin
            addr_d  = if_addr_i;
            len_d   = 3'd4;
            srcIf_d = 1'b1;
            k_d     = 3'd0;
            pend_d  = 1'b0;
            asm_d   = 32'd0;
            state_d = READ;
          end
        end
      end
      READ: begin
        if (!rdy_i) begin
          mem_a_o = prevAddr;
        end else if (srcIf_q && if_clear_i) begin
          pend_d  = 1'b0;
          state_d = IDLE;
        end else begin
          if (k_q < len_q) begin
            mem_a_o = byteAddr;
            k_d     = k_q + 3'd1;
            pend_d  = 1'b1;
          end else begin
            pend_d  = 1'b0;
          end
          if (pend_q) begin
            asm_d = rxAsm;
            if (k_q == len_q) begin
              state_d = GAP;
              if (srcIf_q) begin
                ifData_d  = rxAsm;
                ifValid_d = 1'b1;
              end else begin
                lsbData_d  = rxAsm;
                lsbValid_d = 1'b1;
              end
            end
          end
        end
      end
      WRITE: begin
        mem_a_o    = byteAddr;
        mem_dout_o = wrByte;
        if (rdy_i && !ioStall) begin
          mem_wr_o = 1'b1;
          if (k_q == len_q - 3'd1) begin
            lsbValid_d = 1'b1;
            state_d    = GAP;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      GAP: begin
        if (rdy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request registers; synchronous reset drops any access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      asm_q      <= 32'd0;
      lsbData_q  <= 32'd0;
      ifData_q   <= 32'd0;
      len_q      <= 3'd0;
      k_q        <= 3'd0;
      srcIf_q    <= 1'b0;
      pend_q     <= 1'b0;
      lsbValid_q <= 1'b0;
      ifValid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      asm_q      <= asm_d;
      lsbData_q  <= lsbData_d;
      ifData_q   <= ifData_d;
      len_q      <= len_d;
      k_q        <= k_d;
      srcIf_q    <= srcIf_d;
      pend_q     <= pend_d;
      lsbValid_q <= lsbValid_d;
      ifValid_q  <= ifValid_d;
    end
  end

  assign lsb_data_valid_o = lsbValid_q;
  assign lsb_data_o       = lsbData_q;
  assign if_data_valid_o  = ifValid_q;
  assign if_data_o        = ifData_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a byte RAM model plus a table of LSB
// accesses, followed by hand-written multi-cycle corner-case sequences.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        lsbEnable;
  logic        lsbIsWrite;
  logic [31:0] lsbAddr;
  logic [2:0]  lsbLen;
  logic [31:0] lsbWdata;
  logic        lsbDataValid;
  logic [31:0] lsbData;
  logic        ifEnable;
  logic [31:0] ifAddr;
  logic        ifClear;
  logic        ifDataValid;
  logic [31:0] ifData;
  logic [7:0]  memDin;
  logic [7:0]  memDout;
  logic [31:0] memA;
  logic        memWr;
  logic        ioBufferFull;

  int errors = 0;
  int checks = 0;
  int ioWrites = 0;
  logic [7:0] ioLast = 8'd0;
  int ifPulses = 0;
  logic [7:0] ram [0:8191];

  typedef struct {
    logic        isWrite;
    logic [31:0] addr;
    logic [2:0]  len;
    logic [31:0] wdata;
    logic [31:0] expData;
    int          expEdges;
  } vec_t;

  vec_t vecs [9];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy_i(rdy),
    .lsb_enable_i(lsbEnable), .lsb_is_write_i(lsbIsWrite), .lsb_addr_i(lsbAddr),
    .lsb_len_i(lsbLen), .lsb_wdata_i(lsbWdata),
    .lsb_data_valid_o(lsbDataValid), .lsb_data_o(lsbData),
    .if_enable_i(ifEnable), .if_addr_i(ifAddr), .if_clear_i(ifClear),
    .if_data_valid_o(ifDataValid), .if_data_o(ifData),
    .mem_din_i(memDin), .mem_dout_o(memDout), .mem_a_o(memA), .mem_wr_o(memWr),
    .io_buffer_full_i(ioBufferFull)
  );

  always #5 clk = ~clk;

  // RAM model with one-cycle read latency; IO-space writes are logged instead.
  always @(posedge clk) begin
    if (memWr && memA[17:16] == 2'b11) begin
      ioWrites <= ioWrites + 1;
      ioLast   <= memDout;
    end else if (memWr) begin
      ram[memA[12:0]] <= memDout;
    end
    memDin <= ram[memA[12:0]];
    if (ifDataValid) ifPulses <= ifPulses + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance until the chosen valid is seen, returning the edge count.
  task automatic waitValid(input bit useIf, input string name, output int edges);
    bit seen = 1'b0;
    edges = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      edges = i + 1;
      seen = useIf ? ifDataValid : lsbDataValid;
    end
    if (!seen) checkOutput({name, " timeout"}, 32'd0, 32'd1);
  endtask

  // Issue one LSB request and accept it at the next edge.
  task automatic applyStimulus(input vec_t v);
    lsbIsWrite = v.isWrite;
    lsbAddr    = v.addr;
    lsbLen     = v.len;
    lsbWdata   = v.wdata;
    lsbEnable  = 1'b1;
    tick();
  endtask

  initial begin
    int edges;
    for (int i = 0; i < 8192; i++) ram[i] = 8'(i) ^ 8'hA5;
    ram[13'h1000] = 8'h78; ram[13'h1001] = 8'h56;
    ram[13'h1002] = 8'h34; ram[13'h1003] = 8'h12;

    vecs[0] = '{1'b0, 32'h1000, 3'b100, 32'h0,        32'h12345678, 5};
    vecs[1] = '{1'b0, 32'h1002, 3'b001, 32'h0,        32'h00000034, 2};
    vecs[2] = '{1'b0, 32'h1001, 3'b010, 32'h0,        32'h00003456, 3};
    vecs[3] = '{1'b1, 32'h1100, 3'b100, 32'hCAFEF00D, 32'h0,        4};
    vecs[4] = '{1'b0, 32'h1100, 3'b100, 32'h0,        32'hCAFEF00D, 5};
    vecs[5] = '{1'b1, 32'h1101, 3'b001, 32'h000000AA, 32'h0,        1};
    vecs[6] = '{1'b0, 32'h1100, 3'b100, 32'h0,        32'hCAFEAA0D, 5};
    vecs[7] = '{1'b0, 32'h1000, 3'b111, 32'h0,        32'h12345678, 5};
    vecs[8] = '{1'b0, 32'h0010, 3'b010, 32'h0,        32'h0000B4B5, 3};

    rst = 1'b1; rdy = 1'b1; lsbEnable = 1'b0; lsbIsWrite = 1'b0; lsbAddr = '0;
    lsbLen = 3'b000; lsbWdata = '0; ifEnable = 1'b0; ifAddr = '0; ifClear = 1'b0;
    ioBufferFull = 1'b0;
    tick(); tick();
    checkOutput("reset mem_a", memA, 32'd0);
    checkOutput("reset mem_wr", 32'(memWr), 32'd0);
    checkOutput("reset mem_dout", 32'(memDout), 32'd0);
    checkOutput("reset lsb_valid", 32'(lsbDataValid), 32'd0);
    checkOutput("reset lsb_data", lsbData, 32'd0);
    checkOutput("reset if_data", ifData, 32'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v]);
      if (v == 0) checkOutput("lw first mem_a", memA, 32'h1000);
      waitValid(1'b0, $sformatf("vec%0d", v), edges);
      checkOutput($sformatf("vec%0d latency", v), 32'(edges), 32'(vecs[v].expEdges));
      if (!vecs[v].isWrite)
        checkOutput($sformatf("vec%0d data", v), lsbData, vecs[v].expData);
      lsbEnable = 1'b0;
      tick();
      checkOutput($sformatf("vec%0d pulse width", v), 32'(lsbDataValid), 32'd0);
    end

    // Halfword store: two bus cycles, third byte untouched.
    applyStimulus('{1'b1, 32'h200, 3'b010, 32'h1234BEEF, 32'h0, 2});
    checkOutput("sh c0 addr", memA, 32'h200);
    checkOutput("sh c0 data", 32'(memDout), 32'hEF);
    checkOutput("sh c0 wr", 32'(memWr), 32'd1);
    tick();
    checkOutput("sh c1 addr", memA, 32'h201);
    checkOutput("sh c1 data", 32'(memDout), 32'hBE);
    checkOutput("sh c1 wr", 32'(memWr), 32'd1);
    tick();
    checkOutput("sh valid", 32'(lsbDataValid), 32'd1);
    checkOutput("sh done wr", 32'(memWr), 32'd0);
    lsbEnable = 1'b0;
    tick();
    checkOutput("sh byte 0x202", 32'(ram[13'h202]), 32'hA7);
    checkOutput("sh byte 0x200", 32'(ram[13'h200]), 32'hEF);

    // IO byte store stalled for three cycles by a full UART buffer.
    ioBufferFull = 1'b1;
    applyStimulus('{1'b1, 32'h30000, 3'b001, 32'h00000041, 32'h0, 1});
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("io stall%0d wr", c), 32'(memWr), 32'd0);
      if (c < 2) tick();
    end
    tick();
    ioBufferFull = 1'b0;
    #1;
    checkOutput("io issue wr", 32'(memWr), 32'd1);
    checkOutput("io issue data", 32'(memDout), 32'h41);
    waitValid(1'b0, "io", edges);
    checkOutput("io valid edges after release", 32'(edges), 32'd1);
    lsbEnable = 1'b0;
    tick();
    checkOutput("io write count", 32'(ioWrites), 32'd1);
    checkOutput("io write byte", 32'(ioLast), 32'h41);

    // LSB and IF in the same cycle: LSB first, fetch after the gap.
    ifEnable = 1'b1; ifAddr = 32'h0;
    applyStimulus('{1'b0, 32'h80, 3'b001, 32'h0, 32'h0, 2});
    waitValid(1'b0, "arb lsb", edges);
    checkOutput("arb lsb latency", 32'(edges), 32'd2);
    checkOutput("arb lsb data", lsbData, 32'h00000025);
    checkOutput("arb if not yet", 32'(ifDataValid), 32'd0);
    lsbEnable = 1'b0;
    waitValid(1'b1, "arb if", edges);
    checkOutput("arb if latency", 32'(edges), 32'd7);
    checkOutput("arb if data", ifData, 32'hA6A7A4A5);
    ifEnable = 1'b0;
    tick(); tick();

    // Fetch flushed during its third byte, then a fresh fetch at 0x40.
    ifPulses = 0;
    ifEnable = 1'b1; ifAddr = 32'h0;
    tick();
    tick(); tick();
    checkOutput("clr third byte addr", memA, 32'h2);
    ifClear = 1'b1; ifEnable = 1'b0;
    tick();
    ifClear = 1'b0; ifEnable = 1'b1; ifAddr = 32'h40;
    #1;
    checkOutput("clr idle mem_a", memA, 32'd0);
    tick();
    waitValid(1'b1, "clr refetch", edges);
    checkOutput("clr refetch latency", 32'(edges), 32'd5);
    checkOutput("clr refetch data", ifData, 32'hE6E7E4E5);
    ifEnable = 1'b0;
    tick();
    checkOutput("clr single if pulse", 32'(ifPulses), 32'd1);
    tick();

    // Reset in the middle of a word load.
    applyStimulus(vecs[0]);
    tick(); tick();
    rst = 1'b1; lsbEnable = 1'b0;
    tick();
    checkOutput("rst mem_a", memA, 32'd0);
    checkOutput("rst mem_wr", 32'(memWr), 32'd0);
    checkOutput("rst lsb_data", lsbData, 32'd0);
    checkOutput("rst if_data", ifData, 32'd0);
    checkOutput("rst valids", {30'd0, lsbDataValid, ifDataValid}, 32'd0);
    rst = 1'b0;
    edges = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (lsbDataValid) edges++;
    end
    checkOutput("rst no late valid", 32'(edges), 32'd0);

    // rdy low for two cycles mid-word: same word, two cycles late.
    applyStimulus(vecs[0]);
    tick();
    rdy = 1'b0;
    #1;
    checkOutput("rdy freeze wr", 32'(memWr), 32'd0);
    tick(); tick();
    rdy = 1'b1;
    waitValid(1'b0, "rdy lw", edges);
    checkOutput("rdy lw latency", 32'(edges + 3), 32'd7);
    checkOutput("rdy lw data", lsbData, 32'h12345678);
    lsbEnable = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
